// File: rtl/spi_slave.sv
// spi_slave: mode-0 MSB-first SPI responder oversampling SCLK/SS/MOSI in the CLOCK_50 domain
module spi_slave #(
  parameter int bits_transfer = 16,
  parameter int counter_width = $clog2(bits_transfer),
  parameter int sync_stages = 2
) (
  input  logic                     CLOCK_50,
  input  logic                     rst_n,
  input  logic                     spi_sclk,
  input  logic                     spi_ss_n,
  input  logic                     spi_mosi,
  output logic                     spi_miso,
  output logic                     miso_oe,
  input  logic [bits_transfer-1:0] tx_data,
  output logic                     busy,
  output logic [bits_transfer-1:0] rx_data,
  output logic                     rx_valid,
  output logic                     frame_err
);
  typedef enum logic {IDLE, ACTIVE} state_t;
  localparam logic [counter_width:0] full_cnt = (counter_width+1)'(bits_transfer);
  localparam logic [counter_width:0] sat_cnt = (counter_width+1)'(bits_transfer + 1);
  logic [sync_stages:0] sclk_sh_q, ss_sh_q;
  logic [sync_stages-1:0] mosi_sh_q;
  logic sclk_rise_q, sclk_fall_q, ss_rise_q, ss_fall_q;
  logic sclk_rise_d, sclk_fall_d, ss_rise_d, ss_fall_d;
  state_t state_q, state_d;
  logic [bits_transfer-1:0] tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
  logic [counter_width:0] bit_cnt_q, bit_cnt_d;
  logic spi_miso_q, spi_miso_d, miso_oe_q, miso_oe_d, busy_q, busy_d;
  logic rx_valid_q, rx_valid_d, frame_err_q, frame_err_d;
  always_comb begin
    sclk_rise_d = sclk_sh_q[sync_stages-1] & ~sclk_sh_q[sync_stages];
    sclk_fall_d = ~sclk_sh_q[sync_stages-1] & sclk_sh_q[sync_stages];
    ss_rise_d = ss_sh_q[sync_stages-1] & ~ss_sh_q[sync_stages];
    ss_fall_d = ~ss_sh_q[sync_stages-1] & ss_sh_q[sync_stages];
  end
  always_comb begin
    state_d = state_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d = rx_data_q;
    bit_cnt_d = bit_cnt_q;
    spi_miso_d = spi_miso_q;
    miso_oe_d = miso_oe_q;
    busy_d = busy_q;
    rx_valid_d = 1'b0;
    frame_err_d = 1'b0;
    if (state_q == IDLE) begin
      if (ss_fall_q) begin
        state_d = ACTIVE;
        tx_shift_d = tx_data;
        spi_miso_d = tx_data[bits_transfer-1];
        miso_oe_d = 1'b1;
        busy_d = 1'b1;
        bit_cnt_d = '0;
        rx_shift_d = '0;
      end
    end else if (ss_rise_q) begin
      state_d = IDLE;
      busy_d = 1'b0;
      miso_oe_d = 1'b0;
      spi_miso_d = 1'b0;
      rx_valid_d = bit_cnt_q == full_cnt;
      frame_err_d = bit_cnt_q != full_cnt;
      rx_data_d = rx_valid_d ? rx_shift_q : rx_data_q;
    end else begin
      if (sclk_rise_q) begin
        rx_shift_d = {rx_shift_q[bits_transfer-2:0], mosi_sh_q[sync_stages-1]};
        bit_cnt_d = bit_cnt_q == sat_cnt ? bit_cnt_q : bit_cnt_q + 1'b1;
      end
      if (sclk_fall_q) begin
        tx_shift_d = bit_cnt_q < full_cnt ? tx_shift_q << 1 : tx_shift_q;
        spi_miso_d = bit_cnt_q < full_cnt ? tx_shift_q[bits_transfer-2] : 1'b0;
      end
    end
  end
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sh_q <= '0;
      ss_sh_q <= '1;
      mosi_sh_q <= '0;
      sclk_rise_q <= 1'b0;
      sclk_fall_q <= 1'b0;
      ss_rise_q <= 1'b0;
      ss_fall_q <= 1'b0;
      state_q <= IDLE;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q <= '0;
      bit_cnt_q <= '0;
      spi_miso_q <= 1'b0;
      miso_oe_q <= 1'b0;
      busy_q <= 1'b0;
      rx_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sclk_sh_q <= {sclk_sh_q[sync_stages-1:0], spi_sclk};
      ss_sh_q <= {ss_sh_q[sync_stages-1:0], spi_ss_n};
      mosi_sh_q <= {mosi_sh_q[sync_stages-2:0], spi_mosi};
      sclk_rise_q <= sclk_rise_d;
      sclk_fall_q <= sclk_fall_d;
      ss_rise_q <= ss_rise_d;
      ss_fall_q <= ss_fall_d;
      state_q <= state_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q <= rx_data_d;
      bit_cnt_q <= bit_cnt_d;
      spi_miso_q <= spi_miso_d;
      miso_oe_q <= miso_oe_d;
      busy_q <= busy_d;
      rx_valid_q <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end
  assign spi_miso = spi_miso_q;
  assign miso_oe = miso_oe_q;
  assign busy = busy_q;
  assign rx_data = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign frame_err = frame_err_q;
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: scoreboard bench driving a mode-0 SPI master against spi_slave
module tb_spi_slave;
  localparam int w = 16;
  localparam int h = 20;
  logic CLOCK_50 = 1'b0;
  logic rst_n = 1'b0;
  logic spi_sclk = 1'b0;
  logic spi_ss_n = 1'b1;
  logic spi_mosi = 1'b0;
  logic [w-1:0] tx_data = '0;
  logic spi_miso, miso_oe, busy, rx_valid, frame_err;
  logic [w-1:0] rx_data;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int valid_cyc = 0;
  int ss_rise_cyc = 0;
  logic busy_bad;
  logic [w-1:0] exp_q[$];
  logic [w-1:0] obs_q[$];
  spi_slave dut (
    .CLOCK_50(CLOCK_50), .rst_n(rst_n), .spi_sclk(spi_sclk), .spi_ss_n(spi_ss_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .miso_oe(miso_oe), .tx_data(tx_data),
    .busy(busy), .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err)
  );
  always #10 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc <= cyc + 1;
  always @(negedge CLOCK_50) begin
    if (rx_valid) begin
      obs_q.push_back(rx_data);
      valid_cnt++;
      valid_cyc = cyc;
    end
    if (frame_err) err_cnt++;
    if (rx_valid && frame_err) both_cnt++;
  end
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask
  task automatic pulse(input logic b, output logic m);
    spi_mosi = b;
    wait_cyc(h);
    spi_sclk = 1'b1;
    m = spi_miso;
    if (busy !== 1'b1) busy_bad = 1'b1;
    wait_cyc(h);
    spi_sclk = 1'b0;
  endtask
  task automatic frame(input logic [31:0] word, input int n, output logic [31:0] r);
    logic m;
    r = '0;
    busy_bad = 1'b0;
    spi_ss_n = 1'b0;
    wait_cyc(h);
    for (int i = 0; i < n; i++) begin
      pulse(word[n-1-i], m);
      r = {r[30:0], m};
    end
    wait_cyc(h);
    spi_ss_n = 1'b1;
    ss_rise_cyc = cyc;
  endtask
  task automatic drain(input int k);
    for (int i = 0; i < 80 && obs_q.size() < k; i++) wait_cyc(1);
  endtask
  task automatic test_reset;
    logic [w+4:0] outs;
    wait_cyc(3);
    outs = {spi_miso, miso_oe, busy, rx_valid, frame_err, rx_data};
    checks++;
    if (outs !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    rst_n = 1'b1;
    wait_cyc(10);
    outs = {spi_miso, miso_oe, busy, rx_valid, frame_err, rx_data};
    checks++;
    if (outs !== '0 || valid_cnt != 0 || err_cnt != 0) begin
      failures++;
      $display("FAIL idle_after_reset: outs=%h valid=%0d err=%0d expected all 0", outs, valid_cnt, err_cnt);
    end
  endtask
  task automatic test_normal;
    int v0, e0;
    logic m;
    logic [w-1:0] r, got, want;
    v0 = valid_cnt;
    e0 = err_cnt;
    tx_data = 16'hBEEF;
    exp_q.push_back(16'hDEAD);
    busy_bad = 1'b0;
    r = '0;
    spi_ss_n = 1'b0;
    wait_cyc(3);
    checks++;
    if (miso_oe !== 1'b0) begin
      failures++;
      $display("FAIL oe_early: got %b expected 0", miso_oe);
    end
    wait_cyc(1);
    checks++;
    if ({miso_oe, busy, spi_miso} !== 3'b111) begin
      failures++;
      $display("FAIL first_bit_latency: oe/busy/miso=%b expected 111", {miso_oe, busy, spi_miso});
    end
    tx_data = 16'h0000;
    wait_cyc(h - 4);
    for (int i = 0; i < w; i++) begin
      pulse(1'(16'hDEAD >> (w - 1 - i)), m);
      r = {r[w-2:0], m};
    end
    wait_cyc(h);
    spi_ss_n = 1'b1;
    ss_rise_cyc = cyc;
    drain(1);
    wait_cyc(10);
    want = exp_q.pop_front();
    checks++;
    if (obs_q.size() == 0) begin
      failures++;
      $display("FAIL normal_rx: no rx_valid, expected %h", want);
    end else begin
      got = obs_q.pop_front();
      if (got !== want) begin
        failures++;
        $display("FAIL normal_rx: got %h expected %h", got, want);
      end
    end
    checks++;
    if (valid_cnt - v0 != 1 || err_cnt != e0) begin
      failures++;
      $display("FAIL normal_pulses: valid=%0d err=%0d expected 1 0", valid_cnt - v0, err_cnt - e0);
    end
    checks++;
    if (r !== 16'hBEEF) begin
      failures++;
      $display("FAIL normal_miso: got %h expected beef", r);
    end
    checks++;
    if (busy_bad !== 1'b0 || busy !== 1'b0 || miso_oe !== 1'b0) begin
      failures++;
      $display("FAIL normal_busy: dropped=%b busy=%b oe=%b expected 0 0 0", busy_bad, busy, miso_oe);
    end
    checks++;
    if (valid_cyc - ss_rise_cyc != 4) begin
      failures++;
      $display("FAIL rx_valid_latency: got %0d expected 4", valid_cyc - ss_rise_cyc);
    end
  endtask
  task automatic test_short;
    int v0, e0;
    logic [31:0] r;
    v0 = valid_cnt;
    e0 = err_cnt;
    tx_data = 16'h3C96;
    frame(32'hA5, 8, r);
    wait_cyc(20);
    checks++;
    if (err_cnt - e0 != 1 || valid_cnt != v0) begin
      failures++;
      $display("FAIL short_pulses: err=%0d valid=%0d expected 1 0", err_cnt - e0, valid_cnt - v0);
    end
    checks++;
    if (rx_data !== 16'hDEAD) begin
      failures++;
      $display("FAIL short_hold: got %h expected dead", rx_data);
    end
    checks++;
    if (r[7:0] !== 8'h3C) begin
      failures++;
      $display("FAIL short_miso: got %h expected 3c", r[7:0]);
    end
  endtask
  task automatic test_long;
    int v0, e0;
    logic [31:0] r;
    v0 = valid_cnt;
    e0 = err_cnt;
    tx_data = 16'h8001;
    frame(32'h1ABCD, 17, r);
    wait_cyc(20);
    checks++;
    if (err_cnt - e0 != 1 || valid_cnt != v0) begin
      failures++;
      $display("FAIL long_pulses: err=%0d valid=%0d expected 1 0", err_cnt - e0, valid_cnt - v0);
    end
    checks++;
    if (rx_data !== 16'hDEAD) begin
      failures++;
      $display("FAIL long_hold: got %h expected dead", rx_data);
    end
    checks++;
    if (r[16:0] !== 17'h10002) begin
      failures++;
      $display("FAIL long_miso: got %h expected 10002", r[16:0]);
    end
  endtask
  task automatic test_back_to_back;
    int v0, e0;
    logic [31:0] r1, r2;
    logic [w-1:0] got, want;
    v0 = valid_cnt;
    e0 = err_cnt;
    tx_data = 16'hA55A;
    exp_q.push_back(16'h1234);
    exp_q.push_back(16'h5678);
    frame(32'h1234, 16, r1);
    tx_data = 16'h0F0F;
    wait_cyc(3);
    frame(32'h5678, 16, r2);
    drain(2);
    wait_cyc(10);
    for (int i = 0; i < 2; i++) begin
      want = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL b2b_rx%0d: no rx_valid, expected %h", i, want);
      end else begin
        got = obs_q.pop_front();
        if (got !== want) begin
          failures++;
          $display("FAIL b2b_rx%0d: got %h expected %h", i, got, want);
        end
      end
    end
    checks++;
    if (r1[15:0] !== 16'hA55A || r2[15:0] !== 16'h0F0F) begin
      failures++;
      $display("FAIL b2b_miso: got %h %h expected a55a 0f0f", r1[15:0], r2[15:0]);
    end
    checks++;
    if (valid_cnt - v0 != 2 || err_cnt != e0) begin
      failures++;
      $display("FAIL b2b_pulses: valid=%0d err=%0d expected 2 0", valid_cnt - v0, err_cnt - e0);
    end
  endtask
  task automatic test_reset_mid;
    int v0, e0;
    logic m;
    logic [31:0] r;
    logic [w-1:0] got, want;
    logic [w+4:0] outs;
    v0 = valid_cnt;
    e0 = err_cnt;
    tx_data = 16'hFFFF;
    spi_ss_n = 1'b0;
    wait_cyc(h);
    for (int i = 0; i < 5; i++) pulse(1'b1, m);
    rst_n = 1'b0;
    #1;
    outs = {spi_miso, miso_oe, busy, rx_valid, frame_err, rx_data};
    checks++;
    if (outs !== '0) begin
      failures++;
      $display("FAIL midframe_reset: got %h expected 0", outs);
    end
    spi_ss_n = 1'b1;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(10);
    checks++;
    if (valid_cnt != v0 || err_cnt != e0) begin
      failures++;
      $display("FAIL aborted_pulses: valid=%0d err=%0d expected 0 0", valid_cnt - v0, err_cnt - e0);
    end
    exp_q.push_back(16'hCAFE);
    frame(32'hCAFE, 16, r);
    drain(1);
    wait_cyc(10);
    want = exp_q.pop_front();
    checks++;
    if (obs_q.size() == 0) begin
      failures++;
      $display("FAIL after_reset_rx: no rx_valid, expected %h", want);
    end else begin
      got = obs_q.pop_front();
      if (got !== want || rx_data !== want) begin
        failures++;
        $display("FAIL after_reset_rx: got %h rx_data %h expected %h", got, rx_data, want);
      end
    end
  endtask
  task automatic test_coincident;
    int v0, e0;
    logic m;
    v0 = valid_cnt;
    e0 = err_cnt;
    tx_data = 16'h1357;
    spi_ss_n = 1'b0;
    wait_cyc(h);
    for (int i = 0; i < 15; i++) pulse(i[0], m);
    spi_mosi = 1'b1;
    wait_cyc(h);
    spi_sclk = 1'b1;
    spi_ss_n = 1'b1;
    wait_cyc(h);
    spi_sclk = 1'b0;
    wait_cyc(20);
    checks++;
    if (err_cnt - e0 != 1 || valid_cnt != v0) begin
      failures++;
      $display("FAIL coincident_pulses: err=%0d valid=%0d expected 1 0", err_cnt - e0, valid_cnt - v0);
    end
    checks++;
    if (rx_data !== 16'hCAFE) begin
      failures++;
      $display("FAIL coincident_hold: got %h expected cafe", rx_data);
    end
    checks++;
    if (both_cnt != 0) begin
      failures++;
      $display("FAIL exclusive_pulses: got %0d overlaps expected 0", both_cnt);
    end
  endtask
  initial begin
    test_reset;
    test_normal;
    test_short;
    test_long;
    test_back_to_back;
    test_reset_mid;
    test_coincident;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
SPI responder (mode 0, MSB first) for the far end of the team's SPI master link. It runs entirely in the CLOCK_50 domain and oversamples the asynchronous SCLK, SS and MOSI pins through synchronizers. Each frame receives one bits_transfer-wide word on MOSI and returns a preloaded word on MISO. Completed words go to user logic with a one-cycle valid strobe; malformed frames are flagged.

Parameters:
bits_transfer, 16, frame/word width in bits (min 4)
counter_width, $clog2(bits_transfer), bit counter is counter_width+1 bits wide
sync_stages, 2, flip-flops per input synchronizer (min 2)

Ports:
CLOCK_50  input  1  system clock, 50 MHz
rst_n  input  1  asynchronous active-low reset
spi_sclk  input  1  SPI clock from master; idles low
spi_ss_n  input  1  slave select, active low
spi_mosi  input  1  master-out data
spi_miso  output  1  slave-out data
miso_oe  output  1  1 while selected; top level tri-states MISO when 0
tx_data  input  bits_transfer  word to return; captured at frame start
busy  output  1  1 from frame start until frame end
rx_data  output  bits_transfer  last good received word; held between frames
rx_valid  output  1  one-cycle pulse when rx_data updates
frame_err  output  1  one-cycle pulse on a frame with wrong bit count

Behaviour:
- Reset (async, rst_n=0): state=IDLE; spi_miso=0, miso_oe=0, busy=0, rx_data=0, rx_valid=0, frame_err=0; synchronizers reset to sclk=0, ss_n=1, mosi=0; counters and shift registers cleared. Reset mid-frame aborts the frame with no rx_valid or frame_err.
- Synchronizers: each pin passes through sync_stages flops. An edge detector compares the last stage with one extra flop, giving ss_fall, ss_rise, sclk_rise and sclk_fall, each one cycle wide.
- Timing requirement: each SCLK high and low phase, and SS setup/hold to the first and last SCLK edge, is at least sync_stages+3 CLOCK_50 cycles. The master's divided clock meets this.
- IDLE: miso_oe=0, spi_miso=0, busy=0. On ss_fall: tx_shift<=tx_data, spi_miso<=tx_data[MSB], miso_oe<=1, busy<=1, bit_cnt<=0, rx_shift<=0. Go to ACTIVE.
- ACTIVE:
  - On sclk_rise: rx_shift<={rx_shift[W-2:0], mosi_sync}. bit_cnt increments and saturates at bits_transfer+1.
  - On sclk_fall with bit_cnt<bits_transfer: tx_shift shifts left; spi_miso<=next bit (tx_shift[W-2]).
  - On sclk_fall with bit_cnt>=bits_transfer: spi_miso<=0.
- End of frame (ss_rise in ACTIVE): go to IDLE; busy<=0, miso_oe<=0, spi_miso<=0.
  - If bit_cnt==bits_transfer: rx_data<=rx_shift and rx_valid=1 for exactly one cycle.
  - Otherwise (short or long frame): frame_err=1 for one cycle, and rx_data holds its old value.
- Simultaneous events: if ss_rise coincides with an sclk edge in the same cycle, ss_rise wins and the edge is ignored. ss_fall while ACTIVE cannot occur. sclk edges in IDLE are ignored.
- Latency: rx_valid asserts sync_stages+2 CLOCK_50 cycles after the SS pin rises. The first MISO bit is valid sync_stages+2 cycles after the SS pin falls.
- tx_data may change freely except in the cycle ss_fall is detected.
- Back-to-back frames: a new ss_fall is accepted one cycle after returning to IDLE.
- rx_valid and frame_err are never asserted together.

Test Plan:
1. Normal frame: tx_data=16'hBEEF; master sends 16'hDEAD in mode 0 with a 20-cycle SCLK half-period. Required: rx_data=16'hDEAD, one rx_valid pulse, frame_err=0, MISO bits on master rising edges read 16'hBEEF, busy high for the whole frame.
2. Short frame: 8 SCLK pulses of 8'hA5, then SS high. Required: one frame_err pulse, no rx_valid, rx_data keeps its previous value 16'hDEAD.
3. Long frame: 17 SCLK pulses. Required: frame_err pulse, rx_data unchanged, MISO=0 after the 16th falling edge.
4. Back-to-back: 16'h1234 then 16'h5678 with 3-cycle SS-high gap, tx_data changed to 16'h0F0F between frames. Required: two rx_valid pulses with correct data; second MISO word reads 16'h0F0F.
5. Reset mid-frame: rst_n low after 5 bits, released, then a full frame of 16'hCAFE. Required: all outputs at reset values immediately; no pulse for the aborted frame; rx_data=16'hCAFE afterwards.
6. SS rise coincident with a synchronized sclk_rise on the 16th bit. Required: the edge is ignored, bit_cnt=15, frame_err pulses.
